// File: rtl/gen1_descramble.sv
// Gen1/Gen2 receive descrambler for a 8/16/32-bit PIPE interface.
// One-cycle pipeline: bytes are descrambled serially within a beat, then registered with K-flags and lock status.
module gen1_descramble (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_in_i,
    input  logic [3:0]  data_k_in_i,
    input  logic        data_valid_i,
    input  logic [5:0]  pipe_width_i,
    output logic [31:0] data_out_o,
    output logic [3:0]  data_k_out_o,
    output logic        data_valid_o,
    output logic        locked_o
);

    localparam int          DATA_W       = 32;
    localparam int          BYTES        = DATA_W / 8;
    localparam logic [15:0] LFSR_SEED    = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS    = 16'h0039;
    localparam logic [7:0]  SYM_COM      = 8'hBC;
    localparam logic [7:0]  SYM_SKP      = 8'h1C;
    localparam logic [12:0] CNT_MAX      = 13'd8191;
    localparam logic [12:0] UNLOCK_BEATS = 13'd4096;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Galois form of x^16+x^5+x^4+x^3+1; the bit shifted out of [15] is the mask bit.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[15] ? ({s[14:0], 1'b0} ^ LFSR_TAPS) : {s[14:0], 1'b0};
    endfunction

    function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = lfsr_step(t);
        end
        return t;
    endfunction

    // Mask bit i is taken before shift i, so data bit 0 sees the earliest LFSR output.
    function automatic logic [7:0] lfsr_mask(input logic [15:0] s);
        logic [15:0] t;
        logic [7:0]  m;
        t = s;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = t[15];
            t    = lfsr_step(t);
        end
        return m;
    endfunction

    function automatic logic [2:0] active_bytes(input logic [5:0] width);
        case (width)
            6'd16:   return 3'd2;
            6'd32:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    logic [15:0] lfsr_q;
    logic [12:0] cnt_q;
    lock_state_t state_q;

    logic [15:0] lfsr_p0;
    logic [31:0] data_p0;
    logic [3:0]  k_p0;
    logic        com_p0;
    logic [2:0]  n_act_p0;

    logic [31:0] data_p1;
    logic [3:0]  k_p1;
    logic        vld_p1;

    // Stage 0: serial per-byte descramble across the active lanes
    always_comb begin
        logic [7:0] sym;
        logic       is_k;
        n_act_p0 = active_bytes(pipe_width_i);
        lfsr_p0  = lfsr_q;
        data_p0  = '0;
        k_p0     = '0;
        com_p0   = 1'b0;
        sym      = '0;
        is_k     = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            if (3'(b) < n_act_p0) begin
                sym     = data_in_i[8*b +: 8];
                is_k    = data_k_in_i[b];
                k_p0[b] = is_k;
                if (is_k && sym == SYM_COM) begin
                    data_p0[8*b +: 8] = sym;
                    lfsr_p0           = LFSR_SEED;
                    com_p0            = 1'b1;
                end else if (is_k && sym == SYM_SKP) begin
                    data_p0[8*b +: 8] = sym;
                end else if (is_k) begin
                    data_p0[8*b +: 8] = sym;
                    lfsr_p0           = lfsr_adv8(lfsr_p0);
                end else begin
                    data_p0[8*b +: 8] = sym ^ lfsr_mask(lfsr_p0);
                    lfsr_p0           = lfsr_adv8(lfsr_p0);
                end
            end
        end
    end

    // Stage 1: output register, LFSR state, beat counter and lock FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            state_q <= ST_UNLOCKED;
            data_p1 <= '0;
            k_p1    <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= data_valid_i;
            if (data_valid_i) begin
                lfsr_q  <= lfsr_p0;
                data_p1 <= data_p0;
                k_p1    <= k_p0;
                if (com_p0) begin
                    cnt_q <= '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 13'd1;
                end
            end
            case (state_q)
                ST_UNLOCKED: begin
                    if (data_valid_i && com_p0) begin
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // A COM arriving on the same beat as the timeout keeps the link locked.
                    if (!(data_valid_i && com_p0) && cnt_q >= UNLOCK_BEATS) begin
                        state_q <= ST_UNLOCKED;
                    end
                end
                default: state_q <= ST_UNLOCKED;
            endcase
        end
    end

    assign data_out_o   = data_p1;
    assign data_k_out_o = k_p1;
    assign data_valid_o = vld_p1;
    assign locked_o     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gen1_descramble.sv
// Directed self-checking bench for gen1_descramble.
module tb_gen1_descramble;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_in_i = '0;
    logic [3:0]  data_k_in_i = '0;
    logic        data_valid_i = 1'b0;
    logic [5:0]  pipe_width_i = 6'd8;
    logic [31:0] data_out_o;
    logic [3:0]  data_k_out_o;
    logic        data_valid_o;
    logic        locked_o;

    int total  = 0;
    int passed = 0;

    gen1_descramble dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_in_i    (data_in_i),
        .data_k_in_i  (data_k_in_i),
        .data_valid_i (data_valid_i),
        .pipe_width_i (pipe_width_i),
        .data_out_o   (data_out_o),
        .data_k_out_o (data_k_out_o),
        .data_valid_o (data_valid_o),
        .locked_o     (locked_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic beat(input logic [31:0] d, input logic [3:0] k);
        data_in_i    = d;
        data_k_in_i  = k;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
    endtask

    task automatic idle();
        data_in_i    = 32'h0000_00BC;
        data_k_in_i  = 4'b1111;
        data_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (data_out_o !== 32'h0) $display("FAIL reset_data: got %h want %h", data_out_o, 32'h0); else passed++;
        total++; if (data_k_out_o !== 4'h0) $display("FAIL reset_k: got %b want %b", data_k_out_o, 4'h0); else passed++;
        total++; if (data_valid_o !== 1'b0) $display("FAIL reset_vld: got %b want 0", data_valid_o); else passed++;
        total++; if (locked_o !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked_o); else passed++;
        rst_i = 1'b0;
        idle();
        total++; if (data_valid_o !== 1'b0) $display("FAIL post_reset_vld: got %b want 0", data_valid_o); else passed++;
    endtask

    task automatic test_width8();
        logic [7:0] masks [4] = '{8'hFF, 8'h17, 8'hC0, 8'h14};
        pipe_width_i = 6'd8;
        beat(32'h0000_00BC, 4'b0001);
        total++; if (data_out_o !== 32'h0000_00BC) $display("FAIL w8_com_data: got %h want %h", data_out_o, 32'h0000_00BC); else passed++;
        total++; if (data_k_out_o !== 4'b0001) $display("FAIL w8_com_k: got %b want 0001", data_k_out_o); else passed++;
        total++; if (data_valid_o !== 1'b1) $display("FAIL w8_com_vld: got %b want 1", data_valid_o); else passed++;
        total++; if (locked_o !== 1'b1) $display("FAIL w8_com_locked: got %b want 1", locked_o); else passed++;
        // Upper lanes carry junk and K bits; they are inactive at width 8.
        for (int i = 0; i < 4; i++) begin
            beat({24'hA5A5A5, masks[i]}, 4'b1110);
            total++; if (data_out_o !== 32'h0) $display("FAIL w8_d%0d_data: got %h want %h", i, data_out_o, 32'h0); else passed++;
            total++; if (data_k_out_o !== 4'b0000) $display("FAIL w8_d%0d_k: got %b want 0000", i, data_k_out_o); else passed++;
        end
    endtask

    task automatic test_width32();
        pipe_width_i = 6'd32;
        beat(32'h0000_00BC, 4'b0001);
        total++; if (data_out_o !== 32'hC017_FFBC) $display("FAIL w32_com_data: got %h want %h", data_out_o, 32'hC017_FFBC); else passed++;
        total++; if (data_k_out_o !== 4'b0001) $display("FAIL w32_com_k: got %b want 0001", data_k_out_o); else passed++;
        beat(32'h0, 4'b0000);
        total++; if (data_out_o !== 32'h02E7_B214) $display("FAIL w32_next_data: got %h want %h", data_out_o, 32'h02E7_B214); else passed++;
    endtask

    task automatic test_width16_skp();
        pipe_width_i = 6'd16;
        beat(32'h0000_1CBC, 4'b0011);
        total++; if (data_out_o !== 32'h0000_1CBC) $display("FAIL w16_comskp_data: got %h want %h", data_out_o, 32'h0000_1CBC); else passed++;
        total++; if (data_k_out_o !== 4'b0011) $display("FAIL w16_comskp_k: got %b want 0011", data_k_out_o); else passed++;
        beat(32'h0000_1C1C, 4'b0011);
        total++; if (data_out_o !== 32'h0000_1C1C) $display("FAIL w16_skp_data: got %h want %h", data_out_o, 32'h0000_1C1C); else passed++;
        beat(32'hDEAD_0000, 4'b1100);
        total++; if (data_out_o !== 32'h0000_17FF) $display("FAIL w16_data: got %h want %h", data_out_o, 32'h0000_17FF); else passed++;
        total++; if (data_k_out_o !== 4'b0000) $display("FAIL w16_data_k: got %b want 0000", data_k_out_o); else passed++;
    endtask

    task automatic test_multi_com();
        pipe_width_i = 6'd32;
        beat(32'h00BC_00BC, 4'b0101);
        total++; if (data_out_o !== 32'hFFBC_FFBC) $display("FAIL mcom_data: got %h want %h", data_out_o, 32'hFFBC_FFBC); else passed++;
        total++; if (data_k_out_o !== 4'b0101) $display("FAIL mcom_k: got %b want 0101", data_k_out_o); else passed++;
        beat(32'hBC00_0000, 4'b1000);
        total++; if (data_out_o !== 32'hBC14_C017) $display("FAIL lastcom_data: got %h want %h", data_out_o, 32'hBC14_C017); else passed++;
        total++; if (data_k_out_o !== 4'b1000) $display("FAIL lastcom_k: got %b want 1000", data_k_out_o); else passed++;
        pipe_width_i = 6'd8;
        beat(32'h0, 4'b0000);
        total++; if (data_out_o !== 32'h0000_00FF) $display("FAIL lastcom_next: got %h want %h", data_out_o, 32'h0000_00FF); else passed++;
    endtask

    task automatic test_other_k();
        pipe_width_i = 6'd32;
        beat(32'h0000_FBBC, 4'b0011);
        total++; if (data_out_o !== 32'hC017_FBBC) $display("FAIL otherk_data: got %h want %h", data_out_o, 32'hC017_FBBC); else passed++;
        total++; if (data_k_out_o !== 4'b0011) $display("FAIL otherk_k: got %b want 0011", data_k_out_o); else passed++;
    endtask

    task automatic test_valid_gap();
        pipe_width_i = 6'd8;
        beat(32'h0000_00BC, 4'b0001);
        beat(32'h0, 4'b0000);
        total++; if (data_out_o !== 32'h0000_00FF) $display("FAIL gap_pre: got %h want %h", data_out_o, 32'h0000_00FF); else passed++;
        for (int i = 0; i < 5; i++) begin
            idle();
            total++; if (data_valid_o !== 1'b0) $display("FAIL gap_vld%0d: got %b want 0", i, data_valid_o); else passed++;
            total++; if (data_out_o !== 32'h0000_00FF) $display("FAIL gap_hold%0d: got %h want %h", i, data_out_o, 32'h0000_00FF); else passed++;
        end
        beat(32'h0, 4'b0000);
        total++; if (data_out_o !== 32'h0000_0017) $display("FAIL gap_resume1: got %h want %h", data_out_o, 32'h0000_0017); else passed++;
        total++; if (data_valid_o !== 1'b1) $display("FAIL gap_resume_vld: got %b want 1", data_valid_o); else passed++;
        beat(32'h0, 4'b0000);
        total++; if (data_out_o !== 32'h0000_00C0) $display("FAIL gap_resume2: got %h want %h", data_out_o, 32'h0000_00C0); else passed++;
    endtask

    task automatic test_unlock();
        pipe_width_i = 6'd8;
        beat(32'h0000_00BC, 4'b0001);
        total++; if (locked_o !== 1'b1) $display("FAIL unlock_start: got %b want 1", locked_o); else passed++;
        for (int i = 0; i < 4095; i++) begin
            beat(32'h0, 4'b0000);
        end
        total++; if (locked_o !== 1'b1) $display("FAIL unlock_4095: got %b want 1", locked_o); else passed++;
        beat(32'h0, 4'b0000);
        idle();
        total++; if (locked_o !== 1'b0) $display("FAIL unlock_4096: got %b want 0", locked_o); else passed++;
        beat(32'h0000_00BC, 4'b0001);
        total++; if (locked_o !== 1'b1) $display("FAIL relock: got %b want 1", locked_o); else passed++;
        total++; if (data_out_o !== 32'h0000_00BC) $display("FAIL relock_data: got %h want %h", data_out_o, 32'h0000_00BC); else passed++;
    endtask

    task automatic test_reset_mid();
        pipe_width_i = 6'd8;
        beat(32'h0000_00BC, 4'b0001);
        beat(32'h0, 4'b0000);
        data_in_i    = 32'h0;
        data_k_in_i  = 4'b0000;
        data_valid_i = 1'b1;
        #3;
        rst_i = 1'b1;
        #1;
        total++; if (data_out_o !== 32'h0) $display("FAIL rstmid_data: got %h want %h", data_out_o, 32'h0); else passed++;
        total++; if (data_k_out_o !== 4'h0) $display("FAIL rstmid_k: got %b want 0000", data_k_out_o); else passed++;
        total++; if (data_valid_o !== 1'b0) $display("FAIL rstmid_vld: got %b want 0", data_valid_o); else passed++;
        total++; if (locked_o !== 1'b0) $display("FAIL rstmid_locked: got %b want 0", locked_o); else passed++;
        @(posedge clk_i);
        #1;
        total++; if (data_valid_o !== 1'b0) $display("FAIL rstmid_inflight: got %b want 0", data_valid_o); else passed++;
        rst_i = 1'b0;
        beat(32'h0, 4'b0000);
        total++; if (data_out_o !== 32'h0000_00FF) $display("FAIL rstmid_seed: got %h want %h", data_out_o, 32'h0000_00FF); else passed++;
        total++; if (locked_o !== 1'b0) $display("FAIL rstmid_nolock: got %b want 0", locked_o); else passed++;
        beat(32'h0000_00BC, 4'b0001);
        beat(32'h0, 4'b0000);
        total++; if (data_out_o !== 32'h0000_00FF) $display("FAIL rstmid_com_d: got %h want %h", data_out_o, 32'h0000_00FF); else passed++;
        total++; if (locked_o !== 1'b1) $display("FAIL rstmid_locked_again: got %b want 1", locked_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_width8();
        test_width32();
        test_width16_skp();
        test_multi_com();
        test_other_k();
        test_valid_gap();
        test_unlock();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
